// File: rtl/c4_input_cond.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | c4_input_cond: 2-flop synchroniser + debouncer driving the c4 `a` input. |
// | Option macro C4_COND_PULSE_EN: `a` becomes a one-cycle press pulse.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module c4_input_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       n_clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       a,
  output logic       stable,
  output logic [7:0] press_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_q, a_d;
  logic          stable_q, stable_d;
  logic [7:0]    press_cnt_q, press_cnt_d;

  always_comb begin
    sync1_d     = key_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_cnt_d = press_cnt_q;

    case (state_q)
      IDLE_LO: begin
        if (sync2_q) begin
          state_d = WAIT_HI;
          cnt_d   = C_CNT_ONE;
        end
      end
      WAIT_HI: begin
        // A single low sample during the wait rejects the whole run.
        if (!sync2_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d     = IDLE_HI;
          cnt_d       = '0;
          press_cnt_d = press_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync2_q) begin
          state_d = WAIT_LO;
          cnt_d   = C_CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (sync2_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == C_CNT_MAX) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase

    stable_d = (state_d == IDLE_LO) || (state_d == IDLE_HI);
`ifdef C4_COND_PULSE_EN
    a_d = (state_q == WAIT_HI) && (state_d == IDLE_HI);
`else
    a_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
`endif
  end

  // Falling-edge domain shared with c4, so `a` settles half a period early.
  always_ff @(negedge n_clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE_LO;
      cnt_q       <= '0;
      a_q         <= 1'b0;
      stable_q    <= 1'b1;
      press_cnt_q <= 8'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      stable_q    <= stable_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign a         = a_q;
  assign stable    = stable_q;
  assign press_cnt = press_cnt_q;

endmodule
`default_nettype wire
